pwm_fade: RTL and testbench
===========================

# pwm_fade

Duty-cycle ramp engine that sits directly upstream of the PWM core and drives its `duty` input. A command names a target duty, a step size and a step interval; the block then walks its registered duty output toward the target, one step per interval, and flags completion. It gives LED dimming and motor soft-start without per-step CPU writes from the MMIO subsystem.

## Interface
Parameters:
- `R`, 10: PWM resolution. Duty values are R+1 bits; full scale is 2^R.
- `W`, 16: width of the step-interval counter.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command strobe.
- `cmd_ready`  out  1  high only in IDLE. A command is accepted on `cmd_valid & cmd_ready`.
- `cmd_target`  in  R+1  target duty. Values above 2^R are clamped to 2^R.
- `cmd_step`  in  R+1  duty increment per step. Zero is treated as 1.
- `cmd_interval`  in  W  clock cycles between steps, minus 1.
- `stop`  in  1  abort; freezes duty at its current value.
- `duty`  out  R+1  registered duty; connects to the PWM core `duty` input.
- `busy`  out  1  high in UP or DOWN.
- `done`  out  1  one-cycle pulse when an endpoint is reached.

## Operation
- States: IDLE, UP, DOWN. `cmd_target`, `cmd_step` and `cmd_interval` are latched on accept.
- Accept in IDLE:
  - If target > duty, go to UP.
  - If target < duty, go to DOWN.
  - If target == duty, stay in IDLE and pulse `done`.
- Interval timer:
  - Cleared to 0 on accept.
  - Increments each cycle while busy and wraps after reaching `interval`.
  - Produces `tick` when timer == `interval`, so one tick every interval+1 cycles.
- UP on tick:
  - duty ← min(duty + step, target), computed in R+2 bits with no wrap.
  - When the new duty equals target: pulse `done` and go to IDLE.
- DOWN on tick:
  - duty ← max(duty − step, floor), with borrow detected so there is no underflow.
  - floor = target (0 in breathe mode).
  - When the new duty equals floor: pulse `done` and go to IDLE.
- `stop`:
  - Highest priority, overriding tick and command.
  - In any state: next state is IDLE, duty is held, and no `done` pulse is issued.
  - `cmd_valid` is ignored while `stop` is high.
- Reset values:
  - state IDLE, `duty` 0, `busy` 0, `done` 0, timer 0.
  - `cmd_ready` is 1 from the first cycle after reset.
- Reset mid-ramp: all state is discarded and `duty` returns to 0 immediately on the next edge.

## Timing
- Command accepted at edge N:
  - `busy` = 1 from cycle N+1.
  - The first duty update is visible at cycle N+1+interval+1.
  - Later updates follow every interval+1 cycles.
- `interval` = 0: duty steps every cycle.
- Endpoint step: `done` = 1 for exactly the cycle in which `duty` first shows the endpoint value. `busy` and `cmd_ready` change in that same cycle.
- target == duty on accept: `done` pulses at N+1 and `busy` stays 0.
- `stop` sampled at edge M: `busy` = 0 and `cmd_ready` = 1 at M+1; `duty` is unchanged from M.

## Configuration
- `PWM_FADE_BREATHE_EN`:
  - Defined:
    - Endpoints are 0 and target.
    - Reaching target in UP switches to DOWN; reaching 0 in DOWN switches to UP.
    - `done` pulses at each endpoint. `busy` stays high and `cmd_ready` stays low until `stop`.
    - A command with duty > target starts in DOWN toward 0.
    - A command with target == 0 is treated as the normal target == duty case and returns to IDLE.
  - Undefined: one-shot behaviour as described in Operation; no breathe logic is synthesized.

## Structure
- Shared package `pwm_fade_pkg`:
  - state enum typedef `fade_state_t` (IDLE, UP, DOWN).
  - localparam for the default resolution.
  - function `sat_add`/`sat_sub` (clamped duty arithmetic).
- Sub-module `fade_tick_gen`:
  - W-bit interval counter with `clear`, `en` and `interval` inputs and a `tick` output.
  - Reusable by later timer-based cores.
- Top: FSM, latched command registers, duty register.

## Test plan
- Reset, then command target=100, step=10, interval=3 → duty 10, 20, …, 100, one step every 4 cycles; first update 5 cycles after accept; `done` pulses with duty=100; `busy` falls in the same cycle.
- From duty=100, command target=5, step=30, interval=0 → duty 70, 40, 10, 5 on consecutive cycles; clamped at 5 with no underflow.
- Command target=2000 (R=10) with step=0 → target clamped to 1024; step behaves as 1; ramp ends at 1024.
- Mid-ramp: assert `stop` while `cmd_valid` is also high → duty frozen, IDLE next cycle, no `done`, command not accepted; a new command afterwards is accepted.
- Command target equal to current duty → `done` pulse at N+1, `busy` never set. Assert `reset` mid-ramp → duty=0 and `cmd_ready`=1 next cycle.
- With `PWM_FADE_BREATHE_EN`: target=40, step=20, interval=0 from duty 0 → duty sequence 20, 40, 20, 0, 20, …; `done` pulses at 40 and at 0; `stop` ends it.

Source files
------------

// File: rtl/pwm_fade_pkg.sv
// rtl/pwm_fade_pkg.sv - shared types, defaults and clamped duty arithmetic for pwm_fade
package pwm_fade_pkg;

  localparam int DEFAULT_R = 10;
  localparam int DEFAULT_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    UP,
    DOWN
  } fade_state_t;

  // Widened by one bit so the sum can exceed full scale without wrapping before the clamp.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] lim);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, lim}) ? lim : sum[31:0];
  endfunction

  function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] floor);
    logic [32:0] diff;
    diff = {1'b0, a} - {1'b0, b};
    return (diff[32] || (diff[31:0] < floor)) ? floor : diff[31:0];
  endfunction

endpackage

// File: rtl/pwm_fade_if.sv
// rtl/pwm_fade_if.sv - command handshake bundle for pwm_fade
interface pwm_fade_if
  import pwm_fade_pkg::*;
#(
  parameter int R = DEFAULT_R,
  parameter int W = DEFAULT_W
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic [R:0]   cmd_target;
  logic [R:0]   cmd_step;
  logic [W-1:0] cmd_interval;

  modport master(output cmd_valid, output cmd_target, output cmd_step, output cmd_interval,
                 input cmd_ready);
  modport slave(input cmd_valid, input cmd_target, input cmd_step, input cmd_interval,
                output cmd_ready);
endinterface

// File: rtl/pwm_fade_tick_gen.sv
// rtl/pwm_fade_tick_gen.sv - W-bit interval counter, one tick every interval+1 enabled cycles
module fade_tick_gen #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] interval,
  output logic         tick
);
  logic [W-1:0] cnt;

  assign tick = en && (cnt == interval);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + W'(1);
    end
  end
endmodule

// File: rtl/pwm_fade.sv
// rtl/pwm_fade.sv - duty ramp engine feeding the PWM core duty input
// Optional PWM_FADE_BREATHE_EN: bounce between 0 and target until stop.
module pwm_fade
  import pwm_fade_pkg::*;
#(
  parameter int R = DEFAULT_R,
  parameter int W = DEFAULT_W
) (
  input  logic       clk,
  input  logic       reset,
  pwm_fade_if.slave  cmd,
  input  logic       stop,
  output logic [R:0] duty,
  output logic       busy,
  output logic       done
);
  localparam logic [R:0] FULL = {1'b1, {R{1'b0}}};
  localparam logic [R:0] ONE  = {{R{1'b0}}, 1'b1};

  fade_state_t  state, state_n;
  logic [R:0]   duty_n, tgt_q, tgt_n, step_q, step_n;
  logic [W-1:0] ivl_q, ivl_n;
  logic         done_n, accept, tick;
  logic [R:0]   cmd_tgt_c, cmd_step_c, floor_v, up_v, dn_v;
  logic [31:0]  up_w, dn_w;
  logic         unused_hi;

  assign busy          = (state != IDLE);
  assign cmd.cmd_ready = (state == IDLE);
  assign accept        = cmd.cmd_valid && cmd.cmd_ready && !stop;

  assign cmd_tgt_c  = (cmd.cmd_target > FULL) ? FULL : cmd.cmd_target;
  assign cmd_step_c = (cmd.cmd_step == '0) ? ONE : cmd.cmd_step;

`ifdef PWM_FADE_BREATHE_EN
  assign floor_v = '0;
`else
  assign floor_v = tgt_q;
`endif

  assign up_w      = sat_add(32'(duty), 32'(step_q), 32'(tgt_q));
  assign dn_w      = sat_sub(32'(duty), 32'(step_q), 32'(floor_v));
  assign up_v      = up_w[R:0];
  assign dn_v      = dn_w[R:0];
  assign unused_hi = ^{up_w[31:R+1], dn_w[31:R+1]};

  fade_tick_gen #(.W(W)) u_tick (
    .clk      (clk),
    .reset    (reset),
    .clear    (accept),
    .en       (busy),
    .interval (ivl_q),
    .tick     (tick)
  );

  always_comb begin
    state_n = state;
    duty_n  = duty;
    tgt_n   = tgt_q;
    step_n  = step_q;
    ivl_n   = ivl_q;
    done_n  = 1'b0;
    if (stop) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            tgt_n  = cmd_tgt_c;
            step_n = cmd_step_c;
            ivl_n  = cmd.cmd_interval;
`ifdef PWM_FADE_BREATHE_EN
            if ((cmd_tgt_c == duty) || (cmd_tgt_c == '0)) done_n = 1'b1;
`else
            if (cmd_tgt_c == duty) done_n = 1'b1;
`endif
            else if (cmd_tgt_c > duty) state_n = UP;
            else state_n = DOWN;
          end
        end
        UP: begin
          if (tick) begin
            duty_n = up_v;
            if (up_v == tgt_q) begin
              done_n = 1'b1;
`ifdef PWM_FADE_BREATHE_EN
              state_n = DOWN;
`else
              state_n = IDLE;
`endif
            end
          end
        end
        DOWN: begin
          if (tick) begin
            duty_n = dn_v;
            if (dn_v == floor_v) begin
              done_n = 1'b1;
`ifdef PWM_FADE_BREATHE_EN
              state_n = UP;
`else
              state_n = IDLE;
`endif
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      duty   <= '0;
      done   <= 1'b0;
      tgt_q  <= '0;
      step_q <= '0;
      ivl_q  <= '0;
    end else begin
      state  <= state_n;
      duty   <= duty_n;
      done   <= done_n;
      tgt_q  <= tgt_n;
      step_q <= step_n;
      ivl_q  <= ivl_n;
    end
  end
endmodule

// File: tb/tb_pwm_fade.sv
// tb/tb_pwm_fade.sv - directed self-checking bench for pwm_fade
module tb_pwm_fade;
  localparam int R = 10;
  localparam int W = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       stop;
  logic [R:0] duty;
  logic       busy;
  logic       done;
  int         n_total = 0;
  int         n_bad = 0;

  pwm_fade_if #(.R(R), .W(W)) bus ();

  pwm_fade #(.R(R), .W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .cmd   (bus),
    .stop  (stop),
    .duty  (duty),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input int t, input int s, input int iv);
    bus.cmd_valid    = 1'b1;
    bus.cmd_target   = 11'(t);
    bus.cmd_step     = 11'(s);
    bus.cmd_interval = 16'(iv);
    cyc();
    bus.cmd_valid = 1'b0;
  endtask

  initial begin
    int d2[4];
    int cnt;
    int mid;
    d2 = '{70, 40, 10, 5};
    reset = 1'b1;
    stop = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_target = '0;
    bus.cmd_step = '0;
    bus.cmd_interval = '0;
    @(negedge clk);
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
    check_eq("rst_duty", int'(duty), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_done", int'(done), 0);
    check_eq("rst_ready", int'(bus.cmd_ready), 1);

    // ramp up 0 -> 100, step 10, update every 4 cycles
    send(100, 10, 3);
    check_eq("up_busy_n1", int'(busy), 1);
    check_eq("up_ready_n1", int'(bus.cmd_ready), 0);
    for (int k = 1; k <= 10; k++) begin
      repeat (3) cyc();
      check_eq("up_hold", int'(duty), 10 * (k - 1));
      cyc();
      check_eq("up_step", int'(duty), 10 * k);
      check_eq("up_done", int'(done), (k == 10) ? 1 : 0);
      check_eq("up_busy", int'(busy), (k == 10) ? 0 : 1);
    end
    check_eq("up_ready_end", int'(bus.cmd_ready), 1);
    cyc();
    check_eq("up_done_clr", int'(done), 0);

    // ramp down with clamp at target
    send(5, 30, 0);
    check_eq("dn_start", int'(duty), 100);
    check_eq("dn_busy", int'(busy), 1);
    for (int i = 0; i < 4; i++) begin
      cyc();
      check_eq("dn_step", int'(duty), d2[i]);
      check_eq("dn_done", int'(done), (i == 3) ? 1 : 0);
    end

    // target clamp to full scale, zero step acts as 1
    send(2000, 0, 0);
    check_eq("cl_start", int'(duty), 5);
    cnt = 0;
    mid = 0;
    while (cnt < 2000) begin
      cyc();
      cnt++;
      if (cnt == 500) mid = int'(duty);
      if (done) break;
    end
    check_eq("cl_mid", mid, 505);
    check_eq("cl_steps", cnt, 1019);
    check_eq("cl_final", int'(duty), 1024);
    check_eq("cl_busy", int'(busy), 0);

    // stop on a tick cycle with a command pending
    send(0, 1, 2);
    repeat (8) cyc();
    check_eq("st_pre", int'(duty), 1022);
    stop = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_target = 11'd500;
    bus.cmd_step = 11'd1;
    bus.cmd_interval = 16'd0;
    cyc();
    check_eq("st_duty", int'(duty), 1022);
    check_eq("st_busy", int'(busy), 0);
    check_eq("st_ready", int'(bus.cmd_ready), 1);
    check_eq("st_done", int'(done), 0);
    cyc();
    check_eq("st_idle_cmd_ign", int'(busy), 0);
    check_eq("st_idle_duty", int'(duty), 1022);
    stop = 1'b0;
    bus.cmd_valid = 1'b0;
    cyc();
    check_eq("st_after_done", int'(done), 0);
    send(1000, 11, 0);
    check_eq("st_new_busy", int'(busy), 1);
    cyc();
    check_eq("st_new_s1", int'(duty), 1011);
    cyc();
    check_eq("st_new_s2", int'(duty), 1000);
    check_eq("st_new_done", int'(done), 1);

    // target equals current duty
    send(1000, 5, 4);
    check_eq("eq_done", int'(done), 1);
    check_eq("eq_busy", int'(busy), 0);
    check_eq("eq_ready", int'(bus.cmd_ready), 1);
    check_eq("eq_duty", int'(duty), 1000);
    cyc();
    check_eq("eq_done_clr", int'(done), 0);
    check_eq("eq_busy2", int'(busy), 0);

    // reset mid-ramp
    send(0, 1, 0);
    cyc();
    check_eq("rr_pre", int'(duty), 999);
    reset = 1'b1;
    cyc();
    check_eq("rr_duty", int'(duty), 0);
    check_eq("rr_ready", int'(bus.cmd_ready), 1);
    check_eq("rr_busy", int'(busy), 0);
    reset = 1'b0;
    cyc();
    check_eq("rr_duty2", int'(duty), 0);
    check_eq("rr_busy2", int'(busy), 0);

`ifdef PWM_FADE_BREATHE_EN
    begin
      int bd[5];
      int bdn[5];
      bd = '{20, 40, 20, 0, 20};
      bdn = '{0, 1, 0, 1, 0};
      send(40, 20, 0);
      check_eq("br_busy0", int'(busy), 1);
      for (int i = 0; i < 5; i++) begin
        cyc();
        check_eq("br_duty", int'(duty), bd[i]);
        check_eq("br_done", int'(done), bdn[i]);
        check_eq("br_busy", int'(busy), 1);
      end
      stop = 1'b1;
      cyc();
      stop = 1'b0;
      check_eq("br_stop_busy", int'(busy), 0);
      check_eq("br_stop_duty", int'(duty), 20);
    end
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
